fwd_scoreboard: RTL and testbench
=================================

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter DATA_W, default 32: operand/result width.
REQ-002 Parameter ADDR_W, default 5: register address width.
REQ-003 Parameter DEPTH, default 3: number of tracked in-flight slots (slot 0 = execute, DEPTH-1 = writeback); legal range 2..6.
REQ-004 Parameter NRD, default 2: number of operand read ports.
REQ-005 Parameter LOAD_RDY, default 1: lowest slot index at which load data is valid; legal range 1..DEPTH-1.
REQ-006 Port clk  in  1  single clock, rising edge.
REQ-007 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-008 Port issue_valid  in  1  decode-stage instruction requests entry to slot 0.
REQ-009 Port issue_aw  in  ADDR_W  destination register of the issuing instruction.
REQ-010 Port issue_wr_en  in  1  issuing instruction writes the register file.
REQ-011 Port issue_is_load  in  1  issuing instruction is a load.
REQ-012 Port flush  in  1  kill the issuing instruction and slot 0 (taken branch/jump).
REQ-013 Port rd_addr  in  NRD*ADDR_W  operand addresses of the decode-stage instruction, port i at bits [i*ADDR_W +: ADDR_W].
REQ-014 Port rf_data  in  NRD*DATA_W  register-file read data for each port.
REQ-015 Port stage_data  in  DEPTH*DATA_W  result value currently held in each slot, slot k at [k*DATA_W +: DATA_W].
REQ-016 Port op_data  out  NRD*DATA_W  forwarded operand values.
REQ-017 Port stall  out  1  load-use hazard; decode must hold.
REQ-018 Port wb_en  out  1  register-file write enable for slot DEPTH-1.
REQ-019 Port wb_aw  out  ADDR_W  register-file write address for slot DEPTH-1.
REQ-020 Port fwd_cnt  out  16  saturating count of forwarded operand-port events.
REQ-021 Port stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-022 Each slot holds valid, aw, wr_en, is_load; slot k advances to k+1 every cycle; slot DEPTH-1 retires.
REQ-023 Slot 0 loads {issue_valid & ~stall & ~flush, issue_aw, issue_wr_en, issue_is_load}; otherwise a bubble (valid=0).
REQ-024 flush sets slot 0's next-cycle content to bubble and clears the entry moving from slot 0 to slot 1 to invalid; slots >=1 are unaffected.
REQ-025 Slot k matches port i when valid & wr_en & aw == rd_addr[i] & rd_addr[i] != 0.
REQ-026 op_data[i] = stage_data of the lowest-index matching slot (youngest wins); rf_data[i] when no slot matches or rd_addr[i] == 0.
REQ-027 stall = 1 when, for any port, the youngest matching slot k has is_load and k < LOAD_RDY; combinational, same-cycle.
REQ-028 An older ready match shall not mask a younger unready load match.
REQ-029 When stall and flush are both 1, flush wins: slot 0 gets a bubble, stall is still reported for that cycle.
REQ-030 wb_en = slot[DEPTH-1].valid & wr_en; wb_aw = slot[DEPTH-1].aw; wb_en forced 0 when aw == 0.
REQ-031 fwd_cnt increments by the number of ports with a match in a cycle with issue_valid & ~stall; saturates at 16'hFFFF.
REQ-032 stall_cnt increments by 1 per cycle with stall & issue_valid; saturates at 16'hFFFF.
REQ-033 No combinational path from stage_data or rf_data to stall.

Reset
REQ-034 While rst_n = 0, all slots invalid, fwd_cnt = stall_cnt = 0; hence stall = 0, wb_en = 0, wb_aw = 0, op_data = rf_data.
REQ-035 Reset assertion mid-operation discards all in-flight entries immediately; first issue after deassertion sees no forwarding.

Structure
REQ-036 A shared package holds the slot record type {valid, aw, wr_en, is_load} and the counter width constant 16.
REQ-037 One sub-module, fwd_match, per read port: inputs slot vector, rd_addr, rf_data, stage_data; outputs op_data and per-port hazard bit.

Verification
REQ-038 ALU back-to-back: issue aw=3 data 0x11, next cycle rd_addr[0]=3 -> op_data[0]=stage_data slot 0 = 0x11, stall=0, fwd_cnt=1.
REQ-039 Load-use: issue load aw=4, next cycle rd_addr[1]=4 -> stall=1 one cycle, slot 0 bubble, following cycle op_data[1]=slot 1 data, stall=0, stall_cnt=1.
REQ-040 Youngest-wins: aw=5 in slots 0 and 2 with data 0xA and 0xB, rd_addr[0]=5 -> op_data[0]=0xA.
REQ-041 Register zero: slot 0 writes aw=0 data 0xFF, rd_addr[0]=0 -> op_data[0]=rf_data[0], wb_en=0 at retirement.
REQ-042 Flush: issue aw=6 with flush=1 -> no wb_en for aw=6 DEPTH cycles later; rd_addr=6 next cycle reads rf_data.
REQ-043 Reset mid-flight: three valid slots, pulse rst_n low 1 cycle -> wb_en=0, counters 0, no forwarding on next read.

Source files
------------

// File: rtl/fwd_scoreboard_pkg.sv
// Shared types for the forwarding scoreboard: in-flight slot record, counter width
// and a saturating adder used by the event counters.
package fwd_scoreboard_pkg;

    localparam int CNT_W      = 16;
    // Widest register address a slot record can carry; narrower addresses are zero-extended.
    localparam int MAX_ADDR_W = 8;

    typedef struct packed {
        logic                  valid;
        logic [MAX_ADDR_W-1:0] aw;
        logic                  wrEn;
        logic                  isLoad;
    } slot_t;

    function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/fwd_match.sv
// One operand read port: picks the youngest in-flight producer of rdAddr, else the
// register file, and flags a load whose data is not yet available.
module fwd_match
    import fwd_scoreboard_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_RDY = 1
) (
    input  slot_t [DEPTH-1:0]        slots,
    input  logic  [ADDR_W-1:0]       rdAddr,
    input  logic  [DATA_W-1:0]       rfData,
    input  logic  [DEPTH*DATA_W-1:0] stageData,
    output logic  [DATA_W-1:0]       opData,
    output logic                     hit,
    output logic                     hazard
);

    logic [MAX_ADDR_W-1:0] addrExt;
    logic [DEPTH-1:0]      matchVec;

    assign addrExt = MAX_ADDR_W'(rdAddr);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign matchVec[gi] = slots[gi].valid & slots[gi].wrEn &
                                  (slots[gi].aw == addrExt) & (addrExt != '0);
        end
    endgenerate

    // Walk oldest to youngest so the lowest matching slot has the final say; hazard
    // is taken from that same slot, so an older ready copy cannot hide a young load.
    always_comb begin
        opData = rfData;
        hit    = 1'b0;
        hazard = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (matchVec[k]) begin
                opData = stageData[k*DATA_W +: DATA_W];
                hit    = 1'b1;
                hazard = slots[k].isLoad && (k < LOAD_RDY);
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// In-flight destination tracker: shifts issued instructions through DEPTH slots,
// forwards results to the decode operands, detects load-use stalls, drives writeback.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int NRD      = 2,
    parameter int LOAD_RDY = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_aw,
    input  logic                     issue_wr_en,
    input  logic                     issue_is_load,
    input  logic                     flush,
    input  logic [NRD*ADDR_W-1:0]    rd_addr,
    input  logic [NRD*DATA_W-1:0]    rf_data,
    input  logic [DEPTH*DATA_W-1:0]  stage_data,
    output logic [NRD*DATA_W-1:0]    op_data,
    output logic                     stall,
    output logic                     wb_en,
    output logic [ADDR_W-1:0]        wb_aw,
    output logic [CNT_W-1:0]         fwd_cnt,
    output logic [CNT_W-1:0]         stall_cnt
);

    slot_t [DEPTH-1:0] slotsReg;
    slot_t [DEPTH-1:0] slotsNext;
    logic  [NRD-1:0]   hitVec;
    logic  [NRD-1:0]   hazardVec;
    logic  [CNT_W-1:0] hitCount;
    logic  [CNT_W-1:0] fwdCntReg;
    logic  [CNT_W-1:0] stallCntReg;

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_port
            fwd_match #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .DEPTH    (DEPTH),
                .LOAD_RDY (LOAD_RDY)
            ) u_match (
                .slots     (slotsReg),
                .rdAddr    (rd_addr[gi*ADDR_W +: ADDR_W]),
                .rfData    (rf_data[gi*DATA_W +: DATA_W]),
                .stageData (stage_data),
                .opData    (op_data[gi*DATA_W +: DATA_W]),
                .hit       (hitVec[gi]),
                .hazard    (hazardVec[gi])
            );
        end
    endgenerate

    assign stall = |hazardVec;

    always_comb begin
        slotsNext           = slotsReg;
        slotsNext[0].valid  = issue_valid & ~stall & ~flush;
        slotsNext[0].aw     = MAX_ADDR_W'(issue_aw);
        slotsNext[0].wrEn   = issue_wr_en;
        slotsNext[0].isLoad = issue_is_load;
        // A taken branch also kills the instruction currently in execute.
        slotsNext[1]        = slotsReg[0];
        if (flush) begin
            slotsNext[1].valid = 1'b0;
        end
        for (int k = 2; k < DEPTH; k++) begin
            slotsNext[k] = slotsReg[k-1];
        end
    end

    always_comb begin
        hitCount = '0;
        for (int i = 0; i < NRD; i++) begin
            hitCount = hitCount + CNT_W'(hitVec[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slotsReg    <= '0;
            fwdCntReg   <= '0;
            stallCntReg <= '0;
        end else begin
            slotsReg <= slotsNext;
            if (issue_valid && !stall) begin
                fwdCntReg <= satAdd(fwdCntReg, hitCount);
            end
            if (issue_valid && stall) begin
                stallCntReg <= satAdd(stallCntReg, CNT_W'(1));
            end
        end
    end

    // Register zero is hard-wired, so a retiring write to it is dropped.
    assign wb_en     = slotsReg[DEPTH-1].valid & slotsReg[DEPTH-1].wrEn &
                       (slotsReg[DEPTH-1].aw != '0);
    assign wb_aw     = slotsReg[DEPTH-1].aw[ADDR_W-1:0];
    assign fwd_cnt   = fwdCntReg;
    assign stall_cnt = stallCntReg;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed-vector bench: stimulus queues expected values tagged with a cycle number,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fwd_scoreboard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 3;
    localparam int NRD    = 2;
    localparam logic [31:0] RF0 = 32'hAAAA_0000;
    localparam logic [31:0] RF1 = 32'hBBBB_1111;

    typedef enum int {K_OP0, K_OP1, K_STALL, K_WBEN, K_WBAW, K_FCNT, K_SCNT} kind_t;
    typedef struct {
        int          cyc;
        kind_t       kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic                    clk;
    logic                    rst_n;
    logic                    issue_valid;
    logic [ADDR_W-1:0]       issue_aw;
    logic                    issue_wr_en;
    logic                    issue_is_load;
    logic                    flush;
    logic [NRD*ADDR_W-1:0]   rd_addr;
    logic [NRD*DATA_W-1:0]   rf_data;
    logic [DEPTH*DATA_W-1:0] stage_data;
    logic [NRD*DATA_W-1:0]   op_data;
    logic                    stall;
    logic                    wb_en;
    logic [ADDR_W-1:0]       wb_aw;
    logic [15:0]             fwd_cnt;
    logic [15:0]             stall_cnt;

    chk_t expQ[$];
    int   cyc     = 0;
    int   nChecks = 0;
    int   nPass   = 0;

    fwd_scoreboard #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .NRD      (NRD),
        .LOAD_RDY (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_aw      (issue_aw),
        .issue_wr_en   (issue_wr_en),
        .issue_is_load (issue_is_load),
        .flush         (flush),
        .rd_addr       (rd_addr),
        .rf_data       (rf_data),
        .stage_data    (stage_data),
        .op_data       (op_data),
        .stall         (stall),
        .wb_en         (wb_en),
        .wb_aw         (wb_aw),
        .fwd_cnt       (fwd_cnt),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(kind_t k);
        case (k)
            K_OP0:   return op_data[31:0];
            K_OP1:   return op_data[63:32];
            K_STALL: return {31'b0, stall};
            K_WBEN:  return {31'b0, wb_en};
            K_WBAW:  return {27'b0, wb_aw};
            K_FCNT:  return {16'b0, fwd_cnt};
            default: return {16'b0, stall_cnt};
        endcase
    endfunction

    // Monitor: every negedge, compare all expectations tagged for the current cycle.
    initial begin
        chk_t e;
        logic [31:0] got;
        forever begin
            @(negedge clk);
            while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
                e   = expQ.pop_front();
                got = actual(e.kind);
                nChecks++;
                if (e.cyc != cyc)
                    $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
                else if (got !== e.exp)
                    $display("FAIL %s: cycle %0d got %h expected %h", e.name, cyc, got, e.exp);
                else begin
                    nPass++;
                    $display("ok   %s: cycle %0d value %h", e.name, cyc, got);
                end
            end
        end
    end

    task automatic chk(kind_t k, logic [31:0] v, string nm);
        chk_t e;
        e.cyc  = cyc;
        e.kind = k;
        e.exp  = v;
        e.name = nm;
        expQ.push_back(e);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [4:0] aw, logic wr, logic ld, logic fl,
                         logic [4:0] ra0, logic [4:0] ra1);
        issue_valid   = v;
        issue_aw      = aw;
        issue_wr_en   = wr;
        issue_is_load = ld;
        flush         = fl;
        rd_addr       = {ra1, ra0};
    endtask

    task automatic setStage(logic [31:0] d0, logic [31:0] d1, logic [31:0] d2);
        stage_data = {d2, d1, d0};
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            nextCycle();
            drive(0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        chk_t e;
        rst_n   = 1'b0;
        rf_data = {RF1, RF0};
        setStage(32'h11, 32'h22, 32'h33);
        drive(0, 0, 0, 0, 0, 7, 9);

        // Reset state
        nextCycle();
        chk(K_OP0, RF0, "rst_op0");   chk(K_OP1, RF1, "rst_op1");
        chk(K_STALL, 0, "rst_stall"); chk(K_WBEN, 0, "rst_wben");
        chk(K_WBAW, 0, "rst_wbaw");   chk(K_FCNT, 0, "rst_fcnt");
        chk(K_SCNT, 0, "rst_scnt");
        nextCycle();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);

        // ALU back-to-back forwarding from slot 0
        nextCycle(); drive(1, 3, 1, 0, 0, 0, 0);
        nextCycle(); drive(1, 10, 1, 0, 0, 3, 0);
        chk(K_OP0, 32'h11, "alu_op0"); chk(K_OP1, RF1, "alu_op1_r0");
        chk(K_STALL, 0, "alu_stall");  chk(K_FCNT, 0, "alu_fcnt_pre");
        nextCycle(); drive(0, 0, 0, 0, 0, 0, 0);
        chk(K_FCNT, 1, "alu_fcnt");
        nextCycle(); chk(K_WBEN, 1, "alu_wben3"); chk(K_WBAW, 3, "alu_wbaw3");
        nextCycle(); chk(K_WBEN, 1, "alu_wben10"); chk(K_WBAW, 10, "alu_wbaw10");

        // Load-use stall
        nextCycle(); drive(1, 4, 1, 1, 0, 0, 0);
        chk(K_WBEN, 0, "lu_wben_idle");
        nextCycle(); drive(1, 12, 1, 0, 0, 0, 4); setStage(32'h11, 32'h44, 32'h33);
        chk(K_STALL, 1, "lu_stall"); chk(K_SCNT, 0, "lu_scnt_pre");
        nextCycle();
        chk(K_STALL, 0, "lu_release"); chk(K_OP1, 32'h44, "lu_op1_slot1");
        chk(K_SCNT, 1, "lu_scnt");     chk(K_FCNT, 1, "lu_fcnt_hold");
        nextCycle(); drive(0, 0, 0, 0, 0, 0, 0);
        chk(K_FCNT, 2, "lu_fcnt"); chk(K_WBEN, 1, "lu_wben"); chk(K_WBAW, 4, "lu_wbaw");
        idle(3);

        // Youngest wins (aw 5 in slots 0 and 2)
        nextCycle(); drive(1, 5, 1, 0, 0, 0, 0);
        nextCycle(); drive(1, 7, 1, 0, 0, 0, 0);
        nextCycle(); drive(1, 5, 1, 0, 0, 0, 0);
        nextCycle(); drive(0, 0, 0, 0, 0, 5, 7); setStage(32'hA, 32'h77, 32'hB);
        chk(K_OP0, 32'hA, "yw_op0"); chk(K_OP1, 32'h77, "yw_op1"); chk(K_STALL, 0, "yw_stall");

        // Younger unready load must not be masked by older ready match
        nextCycle(); drive(1, 8, 1, 0, 0, 0, 0);
        chk(K_FCNT, 2, "yw_fcnt_hold");
        nextCycle(); drive(0, 0, 0, 0, 0, 0, 0);
        nextCycle(); drive(1, 8, 1, 1, 0, 0, 0);
        nextCycle(); drive(1, 0, 0, 0, 0, 8, 0);
        chk(K_STALL, 1, "mask_stall");
        nextCycle(); drive(0, 0, 0, 0, 0, 0, 0);
        chk(K_SCNT, 2, "mask_scnt"); chk(K_STALL, 0, "mask_idle");
        idle(3);

        // Register zero never forwards or writes back
        nextCycle(); drive(1, 0, 1, 0, 0, 0, 0);
        nextCycle(); drive(0, 0, 0, 0, 0, 0, 0); setStage(32'hFF, 32'h22, 32'h33);
        chk(K_OP0, RF0, "r0_op0");
        nextCycle();
        nextCycle(); chk(K_WBEN, 0, "r0_wben");

        // Flush kills the issuing instruction and slot 0
        nextCycle(); drive(1, 13, 1, 0, 0, 0, 0);
        nextCycle(); drive(1, 6, 1, 0, 1, 0, 0);
        nextCycle(); drive(0, 0, 0, 0, 0, 6, 13);
        chk(K_OP0, RF0, "fl_op0_rf"); chk(K_OP1, RF1, "fl_op1_killed"); chk(K_WBEN, 0, "fl_wben1");
        nextCycle(); drive(0, 0, 0, 0, 0, 0, 0);
        chk(K_WBEN, 0, "fl_wben2");
        nextCycle(); chk(K_WBEN, 0, "fl_wben3");

        // Stall together with flush: stall reported, load in slot 0 killed
        nextCycle(); drive(1, 9, 1, 1, 0, 0, 0);
        nextCycle(); drive(1, 11, 1, 0, 1, 9, 0);
        chk(K_STALL, 1, "sf_stall");
        nextCycle(); drive(0, 0, 0, 0, 0, 9, 0);
        chk(K_STALL, 0, "sf_nostall"); chk(K_OP0, RF0, "sf_op0_rf"); chk(K_SCNT, 3, "sf_scnt");
        idle(3);

        // Reset mid-flight
        nextCycle(); drive(1, 14, 1, 0, 0, 0, 0);
        nextCycle(); drive(1, 15, 1, 0, 0, 0, 0);
        nextCycle(); drive(1, 16, 1, 0, 0, 0, 0);
        chk(K_FCNT, 2, "mr_fcnt_pre"); chk(K_SCNT, 3, "mr_scnt_pre");
        nextCycle(); rst_n = 1'b0; drive(0, 0, 0, 0, 0, 16, 15);
        chk(K_WBEN, 0, "mr_wben"); chk(K_FCNT, 0, "mr_fcnt"); chk(K_SCNT, 0, "mr_scnt");
        chk(K_OP0, RF0, "mr_op0"); chk(K_OP1, RF1, "mr_op1"); chk(K_STALL, 0, "mr_stall");
        nextCycle(); rst_n = 1'b1; drive(1, 20, 1, 0, 0, 15, 0);
        chk(K_OP0, RF0, "mr_first_op0");
        nextCycle(); drive(0, 0, 0, 0, 0, 0, 0);
        chk(K_FCNT, 0, "mr_first_fcnt");

        repeat (2) @(negedge clk);
        #1;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            nChecks++;
            $display("FAIL %s: never compared, expected %h", e.name, e.exp);
        end
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
